// File: rtl/lvds_frame_rx.sv
// lvds_frame_rx -- LVDS ch0 deframer.
// Hunts for the preamble FFFF,FFFF,AAAA and reads a length word N. It then pushes the
// N payload words, tagged with sof/eof, into a show-ahead FIFO that drives a
// valid/ready stream. Everything runs in the lvds_clk domain.
// Optional feature macro: LVDS_CRC_EN. When defined, one trailer word follows the
// payload and must equal the XOR of all payload words.
module lvds_frame_rx #(
   parameter int DATA_W     = 16,
   parameter int MAX_LEN    = 256,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              lvds_clk,
   input  logic              Rst,
   input  logic [DATA_W-1:0] lvds_ch0,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_sof,
   output logic              o_eof,
   output logic              o_frameErr,
   output logic              o_overflow,
   output logic [15:0]       o_frameCnt
);

   localparam int REM_W = $clog2(MAX_LEN + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = DATA_W + 2;

   localparam logic [DATA_W-1:0] PRE_ONES  = {DATA_W{1'b1}};
   localparam logic [DATA_W-1:0] PRE_ALT   = {(DATA_W/2){2'b10}};
   localparam logic [DATA_W-1:0] MAX_LEN_W = DATA_W'(MAX_LEN);
   localparam logic [DATA_W-1:0] ZERO_W    = {DATA_W{1'b0}};
   localparam logic [REM_W-1:0]  REM_ONE   = {{(REM_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [PTR_W-1:0]  PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_LEN     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CHECK   = 2'd3
   } state_t;

   // Framing state
   state_t             state_r;
   logic [DATA_W-1:0]  in_q_r;
   logic [DATA_W-1:0]  hist_old_r;
   logic [DATA_W-1:0]  hist_mid_r;
   logic [REM_W-1:0]   rem_r;
   logic               first_r;
   logic               frame_err_r;
   logic               overflow_r;
   logic [15:0]        frame_cnt_r;

   // FIFO storage plus the output holding register (the head word)
   logic [ENT_W-1:0]   mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [CNT_W-1:0]   mem_cnt_r;
   logic               out_valid_r;
   logic [DATA_W-1:0]  out_data_r;
   logic               out_sof_r;
   logic               out_eof_r;

   logic               pop_s;
   logic               load_s;
   logic [CNT_W-1:0]   occ_s;
   logic               fifo_full_s;
   logic               space_s;
   logic               push_s;
   logic [ENT_W-1:0]   push_word_s;
   logic               pre_match_s;
   logic               len_bad_s;
   logic               last_word_s;

`ifdef LVDS_CRC_EN
   logic [DATA_W-1:0]  chk_r;
   logic               crc_ok_s;

   // Running checksum update: plain XOR of every payload word
   function automatic logic [DATA_W-1:0] chk_update(input logic [DATA_W-1:0] acc,
                                                    input logic [DATA_W-1:0] word);
      return acc ^ word;
   endfunction
`endif

   // Occupancy counts the head register too, so FIFO_DEPTH words fit in total
   assign pop_s       = out_valid_r & i_ready;
   assign occ_s       = mem_cnt_r + {{PTR_W{1'b0}}, out_valid_r};
   assign fifo_full_s = (occ_s == DEPTH_C);
   assign space_s     = ~fifo_full_s | pop_s;
   assign load_s      = (mem_cnt_r != CNT_ZERO) && (~out_valid_r || pop_s);

   // The window is the two history words plus in_q, so the word after AAAA is the length
   assign pre_match_s = (hist_old_r == PRE_ONES) && (hist_mid_r == PRE_ONES) &&
                        (in_q_r == PRE_ALT);
   assign len_bad_s   = (in_q_r == ZERO_W) || (in_q_r > MAX_LEN_W);
   assign last_word_s = (rem_r == REM_ONE);

   // A payload word is pushed every PAYLOAD cycle unless the FIFO has no room
   always_comb begin
      push_s      = 1'b0;
      push_word_s = {ENT_W{1'b0}};
      if ((state_r == ST_PAYLOAD) && space_s) begin
         push_s      = 1'b1;
         push_word_s = {first_r, last_word_s, in_q_r};
      end else begin
         push_s      = 1'b0;
         push_word_s = {ENT_W{1'b0}};
      end
   end

`ifdef LVDS_CRC_EN
   // Checksum accumulator: cleared while the length is read, folds in each pushed word
   always_ff @(posedge lvds_clk or posedge Rst) begin
      if (Rst) begin
         chk_r <= ZERO_W;
      end else if (state_r == ST_LEN) begin
         chk_r <= ZERO_W;
      end else if (push_s) begin
         chk_r <= chk_update(chk_r, in_q_r);
      end
   end

   assign crc_ok_s = (in_q_r == chk_r);
`endif

   // Framing FSM: input register, preamble hunt, length check, payload push, status
   always_ff @(posedge lvds_clk or posedge Rst) begin
      if (Rst) begin
         state_r     <= ST_HUNT;
         in_q_r      <= ZERO_W;
         hist_old_r  <= ZERO_W;
         hist_mid_r  <= ZERO_W;
         rem_r       <= {REM_W{1'b0}};
         first_r     <= 1'b0;
         frame_err_r <= 1'b0;
         overflow_r  <= 1'b0;
         frame_cnt_r <= 16'h0000;
      end else begin
         in_q_r      <= lvds_ch0;
         frame_err_r <= 1'b0;
         case (state_r)
            ST_HUNT: begin
               hist_old_r <= hist_mid_r;
               hist_mid_r <= in_q_r;
               if (pre_match_s) begin
                  state_r <= ST_LEN;
               end
            end
            ST_LEN: begin
               // History stays zero outside HUNT so payload never forms a stale match
               hist_old_r <= ZERO_W;
               hist_mid_r <= ZERO_W;
               if (len_bad_s) begin
                  frame_err_r <= 1'b1;
                  state_r     <= ST_HUNT;
               end else begin
                  rem_r   <= in_q_r[REM_W-1:0];
                  first_r <= 1'b1;
                  state_r <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               hist_old_r <= ZERO_W;
               hist_mid_r <= ZERO_W;
               if (!space_s) begin
                  // Word dropped: abort the frame, it is left without an eof
                  overflow_r  <= 1'b1;
                  frame_err_r <= 1'b1;
                  state_r     <= ST_HUNT;
               end else begin
                  first_r <= 1'b0;
                  rem_r   <= rem_r - REM_ONE;
                  if (last_word_s) begin
`ifdef LVDS_CRC_EN
                     state_r <= ST_CHECK;
`else
                     frame_cnt_r <= frame_cnt_r + 16'h0001;
                     state_r     <= ST_HUNT;
`endif
                  end
               end
            end
`ifdef LVDS_CRC_EN
            ST_CHECK: begin
               hist_old_r <= ZERO_W;
               hist_mid_r <= ZERO_W;
               if (crc_ok_s) begin
                  frame_cnt_r <= frame_cnt_r + 16'h0001;
               end else begin
                  frame_err_r <= 1'b1;
               end
               state_r <= ST_HUNT;
            end
`endif
            default: begin
               hist_old_r <= ZERO_W;
               hist_mid_r <= ZERO_W;
               state_r    <= ST_HUNT;
            end
         endcase
      end
   end

   // FIFO storage write; contents are don't-care until the pointers cover them
   always_ff @(posedge lvds_clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= push_word_s;
      end
   end

   // FIFO pointers and head register: refill the head whenever it is empty or taken
   always_ff @(posedge lvds_clk or posedge Rst) begin
      if (Rst) begin
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         mem_cnt_r   <= CNT_ZERO;
         out_valid_r <= 1'b0;
         out_data_r  <= ZERO_W;
         out_sof_r   <= 1'b0;
         out_eof_r   <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (load_s) begin
            {out_sof_r, out_eof_r, out_data_r} <= mem_r[rd_ptr_r];
            rd_ptr_r    <= rd_ptr_r + PTR_ONE;
            out_valid_r <= 1'b1;
         end else if (pop_s) begin
            out_valid_r <= 1'b0;
         end
         mem_cnt_r <= mem_cnt_r + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, load_s};
      end
   end

   assign o_data     = out_data_r;
   assign o_valid    = out_valid_r;
   assign o_sof      = out_sof_r;
   assign o_eof      = out_eof_r;
   assign o_frameErr = frame_err_r;
   assign o_overflow = overflow_r;
   assign o_frameCnt = frame_cnt_r;

endmodule
